// File: rtl/rvfpm_pkg.sv
// Shared definitions for the rvfpm issue stage: OP-FP encodings, tracker entry
// layout and the register-class decoder.
package rvfpm_pkg;

  localparam logic [6:0] OP_FP = 7'b1010011;

  // funct7 encodings of the RV32F OP-FP operations
  localparam logic [6:0] F7_FADD     = 7'b0000000;
  localparam logic [6:0] F7_FSUB     = 7'b0000100;
  localparam logic [6:0] F7_FMUL     = 7'b0001000;
  localparam logic [6:0] F7_FDIV     = 7'b0001100;
  localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX  = 7'b0010100;
  localparam logic [6:0] F7_FCMP     = 7'b1010000;
  localparam logic [6:0] F7_FMV_XW   = 7'b1110000;  // also FCLASS.S
  localparam logic [6:0] F7_FCVT_WS  = 7'b1100000;
  localparam logic [6:0] F7_FCVT_SW  = 7'b1101000;
  localparam logic [6:0] F7_FMV_WX   = 7'b1111000;

  // Widest tag a tracker entry can hold; narrower tags are zero-extended.
  localparam int unsigned TAG_W_MAX = 32;

  typedef struct packed {
    logic                 valid;
    logic                 wr_fp;
    logic [4:0]           rd;
    logic [TAG_W_MAX-1:0] id;
  } tracker_entry_t;

  typedef struct packed {
    logic rs1_fp;
    logic rs2_fp;
    logic rd_fp;
    logic legal;
  } decode_t;

  // Classify which register fields of an instruction touch the FP file.
  function automatic decode_t decode_regs(input logic [31:0] instr);
    decode_t    d;
    logic [6:0] f7;
    d  = '0;
    f7 = instr[31:25];
    if (instr[6:0] == OP_FP) begin
      d.legal  = 1'b1;
      d.rs1_fp = !(f7 inside {F7_FMV_WX, F7_FCVT_SW});
      d.rs2_fp = f7 inside {F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV, F7_FSGNJ, F7_FMINMAX, F7_FCMP};
      d.rd_fp  = !(f7 inside {F7_FMV_XW, F7_FCMP, F7_FCVT_WS});
    end
    return d;
  endfunction

endpackage

// File: rtl/rvfpm_issue_tracker.sv
// Shadow of the FPU pipeline: a shift register of issued tags plus the
// per-register pending-write mask and in-flight counter derived from it.
module rvfpm_issue_tracker
  import rvfpm_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned ID_W            = 8
) (
  input  logic                                   ck,
  input  logic                                   rst,
  input  logic                                   i_flush,
  input  logic                                   i_set_valid,
  input  logic [4:0]                             i_set_rd,
  input  logic                                   i_load_valid,
  input  logic                                   i_load_wr_fp,
  input  logic [4:0]                             i_load_rd,
  input  logic [ID_W-1:0]                        i_load_id,
  output logic                                   o_wb_valid,
  output logic                                   o_wb_fp,
  output logic [4:0]                             o_wb_rd,
  output logic [ID_W-1:0]                        o_wb_id,
  output logic [NUM_REGS-1:0]                    o_busy,
  output logic [NUM_REGS-1:0]                    o_retire_mask,
  output logic [$clog2(PIPELINE_STAGES+2)-1:0]   o_inflight
);

  localparam int unsigned CntW = $clog2(PIPELINE_STAGES + 2);

  tracker_entry_t      r_pipe [PIPELINE_STAGES];
  tracker_entry_t      w_tail;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_retire_mask;
  logic [CntW-1:0]     r_inflight;
  logic [CntW-1:0]     w_inflight_d;
  logic                w_unused_tag;

  assign w_tail = r_pipe[PIPELINE_STAGES-1];

  // Masks of registers becoming pending / being released this cycle
  always_comb begin
    w_set_mask    = '0;
    w_retire_mask = '0;
    if (i_set_valid) w_set_mask = NUM_REGS'(1) << i_set_rd;
    if (w_tail.valid && w_tail.wr_fp) w_retire_mask = NUM_REGS'(1) << w_tail.rd;
  end

  // In-flight count: entry entering the shadow pipe vs entry leaving it
  always_comb begin
    w_inflight_d = r_inflight;
    if (i_load_valid && !w_tail.valid) begin
      w_inflight_d = r_inflight + CntW'(1);
    end else if (!i_load_valid && w_tail.valid) begin
      w_inflight_d = r_inflight - CntW'(1);
    end
  end

  // Shadow pipe, busy mask and counter; flush kills everything like reset
  always_ff @(posedge ck) begin
    if (rst || i_flush) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) r_pipe[i] <= '0;
      r_busy     <= '0;
      r_inflight <= '0;
    end else begin
      if (i_load_valid) begin
        r_pipe[0] <= '{valid: 1'b1, wr_fp: i_load_wr_fp, rd: i_load_rd,
                       id: TAG_W_MAX'(i_load_id)};
      end else begin
        r_pipe[0] <= '0;
      end
      for (int i = 1; i < PIPELINE_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
      // A register set and retired on the same edge stays busy.
      r_busy     <= (r_busy & ~w_retire_mask) | w_set_mask;
      r_inflight <= w_inflight_d;
    end
  end

  assign o_wb_valid    = w_tail.valid;
  assign o_wb_fp       = w_tail.wr_fp;
  assign o_wb_rd       = w_tail.rd;
  assign o_wb_id       = w_tail.id[ID_W-1:0];
  assign o_busy        = r_busy;
  assign o_retire_mask = w_retire_mask;
  assign o_inflight    = r_inflight;

  // Tag bits above ID_W are always zero.
  assign w_unused_tag = ^w_tail.id;

endmodule

// File: rtl/rvfpm_issue_stage.sv
// Issue stage in front of the rvfpm pipeline: decodes OP-FP register usage,
// stalls on pending FP registers and drives the registered issue interface.
module rvfpm_issue_stage
  import rvfpm_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned ID_W            = 8
) (
  input  logic                                 ck,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [31:0]                          in_instr,
  input  logic [ID_W-1:0]                      in_id,
  input  logic                                 flush,
  output logic [31:0]                          instruction,
  output logic                                 enable,
  output logic [ID_W-1:0]                      issue_id,
  output logic                                 illegal,
  output logic                                 wb_valid,
  output logic                                 wb_fp,
  output logic [4:0]                           wb_rd,
  output logic [ID_W-1:0]                      wb_id,
  output logic [NUM_REGS-1:0]                  busy,
  output logic [$clog2(PIPELINE_STAGES+2)-1:0] inflight
);

  decode_t             w_dec;
  logic [NUM_REGS-1:0] w_need;
  logic [NUM_REGS-1:0] w_retire_mask;
  logic                w_hazard;
  logic                w_xfer;

  logic [31:0]         r_instruction;
  logic                r_enable;
  logic [ID_W-1:0]     r_issue_id;
  logic                r_illegal;
  logic                r_wr_fp;
  logic [4:0]          r_rd;

  assign w_dec = decode_regs(in_instr);

  // Registers this instruction needs free; a register retiring now counts as free
  always_comb begin
    w_need = '0;
    if (w_dec.rs1_fp) w_need = w_need | (NUM_REGS'(1) << in_instr[19:15]);
    if (w_dec.rs2_fp) w_need = w_need | (NUM_REGS'(1) << in_instr[24:20]);
    if (w_dec.rd_fp)  w_need = w_need | (NUM_REGS'(1) << in_instr[11:7]);
    w_hazard = |(w_need & busy & ~w_retire_mask);
  end

  assign in_ready = !rst && !flush && !w_hazard;
  assign w_xfer   = in_valid && in_ready;

  // Issue registers: strobe for one cycle, word and tag hold between issues
  always_ff @(posedge ck) begin
    if (rst) begin
      r_instruction <= '0;
      r_enable      <= 1'b0;
      r_issue_id    <= '0;
      r_illegal     <= 1'b0;
      r_wr_fp       <= 1'b0;
      r_rd          <= '0;
    end else begin
      r_enable  <= w_xfer && w_dec.legal;
      r_illegal <= w_xfer && !w_dec.legal;
      if (w_xfer && w_dec.legal) begin
        r_instruction <= in_instr;
        r_issue_id    <= in_id;
        r_wr_fp       <= w_dec.rd_fp;
        r_rd          <= in_instr[11:7];
      end
    end
  end

  rvfpm_issue_tracker #(
    .NUM_REGS        (NUM_REGS),
    .PIPELINE_STAGES (PIPELINE_STAGES),
    .ID_W            (ID_W)
  ) u_tracker (
    .ck            (ck),
    .rst           (rst),
    .i_flush       (flush),
    .i_set_valid   (w_xfer && w_dec.legal && w_dec.rd_fp),
    .i_set_rd      (in_instr[11:7]),
    .i_load_valid  (r_enable),
    .i_load_wr_fp  (r_wr_fp),
    .i_load_rd     (r_rd),
    .i_load_id     (r_issue_id),
    .o_wb_valid    (wb_valid),
    .o_wb_fp       (wb_fp),
    .o_wb_rd       (wb_rd),
    .o_wb_id       (wb_id),
    .o_busy        (busy),
    .o_retire_mask (w_retire_mask),
    .o_inflight    (inflight)
  );

  assign instruction = r_instruction;
  assign enable      = r_enable;
  assign issue_id    = r_issue_id;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_rvfpm_issue_stage.sv
// Directed bench for rvfpm_issue_stage with hand-computed expectations
// (NUM_REGS=32, PIPELINE_STAGES=4, ID_W=8).
module tb_rvfpm_issue_stage;

  logic        ck;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_id;
  logic        flush;
  logic [31:0] instruction;
  logic        enable;
  logic [7:0]  issue_id;
  logic        illegal;
  logic        wb_valid;
  logic        wb_fp;
  logic [4:0]  wb_rd;
  logic [7:0]  wb_id;
  logic [31:0] busy;
  logic [2:0]  inflight;

  int n_tests = 0;
  int n_fail  = 0;

  rvfpm_issue_stage #(
    .NUM_REGS        (32),
    .PIPELINE_STAGES (4),
    .ID_W            (8)
  ) dut (
    .ck          (ck),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_id       (in_id),
    .flush       (flush),
    .instruction (instruction),
    .enable      (enable),
    .issue_id    (issue_id),
    .illegal     (illegal),
    .wb_valid    (wb_valid),
    .wb_fp       (wb_fp),
    .wb_rd       (wb_rd),
    .wb_id       (wb_id),
    .busy        (busy),
    .inflight    (inflight)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  localparam logic [6:0] F_ADD   = 7'b0000000;
  localparam logic [6:0] F_MUL   = 7'b0001000;
  localparam logic [6:0] F_SGNJ  = 7'b0010000;
  localparam logic [6:0] F_MIN   = 7'b0010100;
  localparam logic [6:0] F_MVXW  = 7'b1110000;

  function automatic logic [31:0] fp_op(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [7:0] id);
    in_valid = v;
    in_instr = instr;
    in_id    = id;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n_stall;
    int n_wb;
    logic [7:0] last_wb_id;

    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 32'h002081D3, 8'h11);
    tick(); tick();
    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_enable", enable, 0);
    check("rst_instruction", instruction, 0);
    check("rst_busy", busy, 0);
    check("rst_inflight", inflight, 0);
    check("rst_wb_valid", wb_valid, 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    tick();

    // Single FADD.S f3,f1,f2 end to end
    drive(1'b1, 32'h002081D3, 8'h11);
    check("single_ready", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    check("single_enable", enable, 1);
    check("single_instr", instruction, 32'h002081D3);
    check("single_issue_id", issue_id, 8'h11);
    check("single_busy", busy, 32'h8);
    tick();
    check("single_enable_off", enable, 0);
    check("single_inflight", inflight, 1);
    tick(); tick();
    check("single_wb_early", wb_valid, 0);
    tick();
    check("single_wb_valid", wb_valid, 1);
    check("single_wb_rd", wb_rd, 3);
    check("single_wb_id", wb_id, 8'h11);
    check("single_wb_fp", wb_fp, 1);
    tick();
    check("single_busy_clr", busy, 0);
    check("single_wb_off", wb_valid, 0);
    check("single_inflight_0", inflight, 0);

    // RAW: FMUL.S f4,f3,f1 behind FADD.S f3,f1,f2
    drive(1'b1, fp_op(F_ADD, 5'd2, 5'd1, 5'd3), 8'h21);
    tick();
    drive(1'b1, fp_op(F_MUL, 5'd1, 5'd3, 5'd4), 8'h22);
    n_stall = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) break;
      n_stall++;
      tick();
    end
    check("raw_stall_cycles", n_stall, 4);
    check("raw_wb_same_cycle", wb_valid, 1);
    check("raw_wb_rd", wb_rd, 3);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    check("raw_enable", enable, 1);
    check("raw_issue_id", issue_id, 8'h22);
    check("raw_busy", busy, 32'h10);
    repeat (6) tick();
    check("raw_drained", inflight, 0);

    // Independent stream, no bubbles
    drive(1'b1, fp_op(F_SGNJ, 5'd7, 5'd6, 5'd5), 8'h31);
    tick();
    check("stream_en0", enable, 1);
    check("stream_id0", issue_id, 8'h31);
    drive(1'b1, fp_op(F_MIN, 5'd10, 5'd9, 5'd8), 8'h32);
    tick();
    check("stream_en1", enable, 1);
    check("stream_id1", issue_id, 8'h32);
    drive(1'b1, fp_op(F_MVXW, 5'd0, 5'd2, 5'd1), 8'h33);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    check("stream_en2", enable, 1);
    check("stream_id2", issue_id, 8'h33);
    tick();
    check("stream_inflight", inflight, 3);
    check("stream_busy", busy, 32'h120);
    tick();
    check("stream_wb0", wb_id, 8'h31);
    tick(); tick();
    check("stream_wb2_valid", wb_valid, 1);
    check("stream_wb2_fp", wb_fp, 0);
    check("stream_wb2_rd", wb_rd, 1);
    check("stream_wb2_id", wb_id, 8'h33);
    tick();
    check("stream_busy_end", busy, 0);
    check("stream_inflight_end", inflight, 0);

    // Full tracker: f1..f4, then a reader of f1
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, fp_op(F_ADD, 5'd11, 5'd10, 5'(k)), 8'(8'h40 + k));
      tick();
    end
    drive(1'b1, fp_op(F_ADD, 5'd12, 5'd1, 5'd5), 8'h45);
    check("full_stall", in_ready, 0);
    check("full_inflight3", inflight, 3);
    tick();
    check("full_inflight4", inflight, 4);
    check("full_busy", busy, 32'h1E);
    check("full_wb_id", wb_id, 8'h41);
    check("full_ready_on_retire", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    check("full_enable", enable, 1);
    check("full_issue_id", issue_id, 8'h45);
    check("full_busy_after", busy, 32'h3C);
    repeat (6) tick();
    check("full_drained", inflight, 0);

    // Flush with 3 in flight
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, fp_op(F_ADD, 5'd11, 5'd10, 5'(k)), 8'(8'h50 + k));
      tick();
    end
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("flush_pre_inflight", inflight, 3);
    flush = 1'b1;
    drive(1'b1, fp_op(F_ADD, 5'd11, 5'd10, 5'd6), 8'h5F);
    check("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    check("flush_busy", busy, 0);
    check("flush_inflight", inflight, 0);
    check("flush_enable", enable, 0);
    check("flush_wb", wb_valid, 0);
    drive(1'b1, 32'h002081D3, 8'h54);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    check("postflush_enable", enable, 1);
    check("postflush_id", issue_id, 8'h54);
    check("postflush_busy", busy, 32'h8);
    n_wb = 0;
    last_wb_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (wb_valid) begin
        n_wb++;
        last_wb_id = wb_id;
      end
      tick();
    end
    check("postflush_wb_count", n_wb, 1);
    check("postflush_wb_id", last_wb_id, 8'h54);

    // Illegal word, then reset mid-stream
    drive(1'b1, fp_op(F_ADD, 5'd2, 5'd1, 5'd7), 8'h60);
    tick();
    drive(1'b1, 32'h00000013, 8'h61);
    check("ill_ready", in_ready, 1);
    tick();
    check("ill_pulse", illegal, 1);
    check("ill_enable", enable, 0);
    check("ill_busy", busy, 32'h80);
    check("ill_issue_id_hold", issue_id, 8'h60);
    check("ill_instr_hold", instruction, fp_op(F_ADD, 5'd2, 5'd1, 5'd7));
    drive(1'b1, fp_op(F_ADD, 5'd2, 5'd1, 5'd8), 8'h62);
    tick();
    check("ill_pulse_off", illegal, 0);
    check("ill_next_enable", enable, 1);
    check("ill_next_busy", busy, 32'h180);
    rst = 1'b1;
    drive(1'b0, 32'h0, 8'h0);
    check("midrst_ready", in_ready, 0);
    tick();
    check("midrst_instr", instruction, 0);
    check("midrst_enable", enable, 0);
    check("midrst_issue_id", issue_id, 0);
    check("midrst_illegal", illegal, 0);
    check("midrst_wb", {wb_valid, wb_fp, wb_rd, wb_id}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_inflight", inflight, 0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
